// File: rtl/arp_step_sequencer.sv
// Arpeggiator note source: steps through a small writable table of period words
// at a fixed tempo and presents the current word with a one-cycle new-note strobe.
module arp_step_sequencer #(
    parameter int N_SLOTS    = 4,
    parameter int IDX_W      = 2,
    parameter int PERIOD_W   = 32,
    parameter int STEP_TICKS = 10000000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WR_EN,
    input  logic [IDX_W-1:0]    WR_ADDR,
    input  logic [PERIOD_W-1:0] WR_DATA,
    input  logic [1:0]          MODE,
    input  logic                RUN,
    output logic [PERIOD_W-1:0] PITCH,
    output logic                NOTE_STB,
    output logic [IDX_W-1:0]    STEP_IDX,
    output logic                GATE
);
    localparam int               CNT_W    = $clog2(STEP_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLOTS - 1);
    localparam logic [IDX_W:0]   SLOTS    = (IDX_W+1)'(N_SLOTS);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UPDN = 2'b10;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                up, up_nxt;
    logic                load;
    logic                stb;
    logic [PERIOD_W-1:0] pitch;
    logic [PERIOD_W-1:0] table_q [N_SLOTS];

    // Returns {direction_up, next_index}; index wraps modulo N_SLOTS.
    function automatic logic [IDX_W:0] advance(input logic [IDX_W-1:0] cur,
                                               input logic [1:0]       mode,
                                               input logic             dir_up);
        logic [IDX_W-1:0] nidx;
        logic             nup;
        nidx = cur;
        nup  = dir_up;
        if (N_SLOTS > 1) begin
            case (mode)
                MODE_UP: begin
                    nidx = (cur == IDX_LAST) ? '0 : cur + 1'b1;
                    nup  = 1'b1;
                end
                MODE_DOWN: begin
                    nidx = (cur == '0) ? IDX_LAST : cur - 1'b1;
                    nup  = 1'b0;
                end
                MODE_UPDN: begin
                    // At an endpoint always move inward, otherwise keep going.
                    if (cur == '0)
                        nup = 1'b1;
                    else if (cur == IDX_LAST)
                        nup = 1'b0;
                    nidx = nup ? cur + 1'b1 : cur - 1'b1;
                    if (nidx == IDX_LAST)
                        nup = 1'b0;
                    else if (nidx == '0)
                        nup = 1'b1;
                end
                default: ;
            endcase
        end else begin
            nidx = '0;
        end
        return {nup, nidx};
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        up_nxt    = up;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (RUN) begin
                    state_nxt = PLAY;
                    load      = 1'b1;
                    idx_nxt   = (MODE == MODE_DOWN) ? IDX_LAST : '0;
                    up_nxt    = (MODE != MODE_DOWN);
                end
            end
            PLAY: begin
                // Stopping wins over a step event in the same cycle.
                if (!RUN) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt           = '0;
                    load              = 1'b1;
                    {up_nxt, idx_nxt} = advance(idx, MODE, up);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pitch reads the table before a same-edge write lands, so a colliding write is heard next visit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            up    <= 1'b1;
            stb   <= 1'b0;
            pitch <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            up    <= up_nxt;
            stb   <= load;
            if (load)
                pitch <= table_q[idx_nxt];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_SLOTS; i++)
                table_q[i] <= '0;
        end else if (WR_EN && ({1'b0, WR_ADDR} < SLOTS)) begin
            table_q[WR_ADDR] <= WR_DATA;
        end
    end

    assign PITCH    = pitch;
    assign NOTE_STB = stb;
    assign STEP_IDX = idx;
    assign GATE     = (state == PLAY) && (pitch != '0);

endmodule

// File: tb/tb_arp_step_sequencer.sv
// Bench for arp_step_sequencer: pattern vectors from a table, expected notes
// queued on a scoreboard and popped on each NOTE_STB, plus hand-written corner cases.
module tb_arp_step_sequencer;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WR_EN;
    logic [1:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic [1:0]  MODE;
    logic        RUN;
    logic [31:0] PITCH;
    logic        NOTE_STB;
    logic [1:0]  STEP_IDX;
    logic        GATE;

    arp_step_sequencer #(
        .N_SLOTS(4), .IDX_W(2), .PERIOD_W(32), .STEP_TICKS(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .MODE(MODE), .RUN(RUN), .PITCH(PITCH),
        .NOTE_STB(NOTE_STB), .STEP_IDX(STEP_IDX), .GATE(GATE)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] pitch;
    } exp_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [3:0]  n;
        logic [31:0] seq;   // nibble k (from LSB) = k-th expected slot
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] tb_tab [4];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          last_stb = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        step();
        WR_EN = 1'b0;
        tb_tab[a] = d;
    endtask

    task automatic push(input logic [1:0] i);
        exp_t e;
        e.idx   = i;
        e.pitch = tb_tab[i];
        sb_q.push_back(e);
    endtask

    task automatic start_run(input logic [1:0] m);
        MODE     = m;
        RUN      = 1'b1;
        last_stb = -1;
    endtask

    task automatic expect_strobe(input string name);
        int   waited;
        exp_t e;
        waited = 0;
        while (1) begin
            step();
            waited++;
            if (NOTE_STB) break;
            if (waited >= 12) begin
                n_total++;
                $display("FAIL %s: no NOTE_STB within %0d cycles, expected one", name, waited);
                return;
            end
        end
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: unexpected NOTE_STB, scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, " idx"},   32'(STEP_IDX), 32'(e.idx));
        chk({name, " pitch"}, PITCH, e.pitch);
        chk({name, " gate"},  32'(GATE), 32'(e.pitch != 0));
        if (last_stb >= 0)
            chk({name, " strobe gap"}, 32'(cyc - last_stb), 32'd4);
        last_stb = cyc;
    endtask

    task automatic stop_and_check(input string name);
        RUN = 1'b0;
        step();
        chk({name, " idle gate"}, 32'(GATE), 32'd0);
        chk({name, " idle stb"},  32'(NOTE_STB), 32'd0);
        chk({name, " sb empty"},  32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{mode: 2'b00, n: 4'd5, seq: 32'h0000_3210};
        vecs[1] = '{mode: 2'b01, n: 4'd5, seq: 32'h0003_0123};
        vecs[2] = '{mode: 2'b10, n: 4'd8, seq: 32'h1012_3210};
        vecs[3] = '{mode: 2'b11, n: 4'd4, seq: 32'h0000_0000};
        vecs[4] = '{mode: 2'b00, n: 4'd4, seq: 32'h0000_3210};

        RST_N = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; MODE = '0; RUN = 1'b0;
        for (int i = 0; i < 4; i++) tb_tab[i] = '0;

        // Reset state
        #2 RST_N = 1'b0;
        step(); step();
        chk("reset pitch", PITCH, 32'd0);
        chk("reset stb",   32'(NOTE_STB), 32'd0);
        chk("reset gate",  32'(GATE), 32'd0);
        chk("reset idx",   32'(STEP_IDX), 32'd0);
        RST_N = 1'b1;
        step();

        wr(2'd0, 32'd191116);
        wr(2'd1, 32'd340529);
        wr(2'd2, 32'd286352);
        wr(2'd3, 32'd227272);

        // Pattern vectors; the last one replays "up" with slot 2 as a rest
        for (int v = 0; v < 5; v++) begin
            if (v == 4) wr(2'd2, 32'd0);
            for (int k = 0; k < int'(vecs[v].n); k++)
                push(2'(vecs[v].seq[4*k +: 4]));
            start_run(vecs[v].mode);
            for (int k = 0; k < int'(vecs[v].n); k++)
                expect_strobe($sformatf("vec%0d step%0d", v, k));
            stop_and_check($sformatf("vec%0d", v));
        end
        wr(2'd2, 32'd286352);

        // Write collides with the step event into slot 1
        push(2'd0);
        start_run(2'b00);
        expect_strobe("coll slot0");
        step(); step(); step();
        WR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 32'd100;
        push(2'd1);
        expect_strobe("coll old value");
        WR_EN = 1'b0;
        tb_tab[1] = 32'd100;
        push(2'd2); push(2'd3); push(2'd0); push(2'd1);
        expect_strobe("coll slot2");
        expect_strobe("coll slot3");
        expect_strobe("coll slot0 again");
        expect_strobe("coll new value");

        // Stop on the step-event cycle
        step(); step(); step();
        RUN = 1'b0;
        step();
        chk("stop stb",   32'(NOTE_STB), 32'd0);
        chk("stop gate",  32'(GATE), 32'd0);
        chk("stop pitch", PITCH, 32'd100);
        chk("stop idx",   32'(STEP_IDX), 32'd1);
        step(); step();
        chk("stop hold pitch", PITCH, 32'd100);
        chk("stop hold stb",   32'(NOTE_STB), 32'd0);
        push(2'd0);
        start_run(2'b00);
        expect_strobe("restart");

        // Asynchronous reset between clock edges
        step(); step();
        chk("pre-reset gate", 32'(GATE), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("async rst pitch", PITCH, 32'd0);
        chk("async rst stb",   32'(NOTE_STB), 32'd0);
        chk("async rst gate",  32'(GATE), 32'd0);
        chk("async rst idx",   32'(STEP_IDX), 32'd0);
        RUN = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        for (int i = 0; i < 4; i++) tb_tab[i] = '0;
        for (int k = 0; k < 4; k++) push(2'(k));
        start_run(2'b00);
        for (int k = 0; k < 4; k++)
            expect_strobe($sformatf("post-reset slot%0d", k));
        stop_and_check("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/arp_step_sequencer.md
Name: arp_step_sequencer

Overview:
- Upstream note source for the square-wave tone generator.
- Holds a small writable table of half-period/period words, expressed as CLK counts at 50 MHz.
- Steps through the table at a fixed tempo in a selectable pattern: up, down, up-down or hold.
- Presents the current period word plus a one-cycle new-note strobe. The tone generator uses the word directly as its pitch compare value.

Parameters:
- N_SLOTS, 4, number of table entries; legal range 1..16.
- IDX_W, 2, index width; must equal ceil(log2(N_SLOTS)), minimum 1.
- PERIOD_W, 32, width of each period word.
- STEP_TICKS, 10000000, CLK cycles per step; 0.2 s at 50 MHz; minimum 2.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  table write enable.
- WR_ADDR  in  IDX_W  table write slot; writes with WR_ADDR >= N_SLOTS are ignored.
- WR_DATA  in  PERIOD_W  period word to store; 0 marks a rest.
- MODE  in  2  pattern: 00 up, 01 down, 10 up-down, 11 hold.
- RUN  in  1  level; 1 = play, 0 = stop.
- PITCH  out  PERIOD_W  registered period word of the current step.
- NOTE_STB  out  1  one-cycle pulse, coincident with the first cycle a new PITCH is valid.
- STEP_IDX  out  IDX_W  slot currently playing.
- GATE  out  1  1 when playing and PITCH != 0.

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset, immediate and mid-operation:
  - all table entries 0, PITCH 0, NOTE_STB 0, STEP_IDX 0, GATE 0;
  - tick counter 0, direction flag up, state IDLE.
- States: IDLE, PLAY.
- IDLE:
  - Outputs hold; GATE 0; tick counter held at 0.
  - RUN=1 sampled → next cycle: state PLAY, STEP_IDX = start, PITCH = table[start], NOTE_STB=1, tick counter 0.
  - start = N_SLOTS-1 for MODE 01, else 0. Direction flag = down for MODE 01, else up.
- PLAY:
  - Tick counter increments each cycle.
  - Step event when counter == STEP_TICKS-1. Next cycle: counter 0, STEP_IDX advances, PITCH = table[new idx], NOTE_STB=1.
  - NOTE_STB period is therefore exactly STEP_TICKS cycles.
  - RUN=0 sampled → next cycle IDLE. RUN=0 has priority over a same-cycle step event.
  - On stop: PITCH and STEP_IDX hold, GATE 0, no strobe.
- Advance rules:
  - up: idx+1, wrapping N_SLOTS-1 → 0.
  - down: idx-1, wrapping 0 → N_SLOTS-1.
  - up-down: ping-pong without repeating endpoints (0,1,2,3,2,1,0,1,…). The direction flag flips on reaching an endpoint.
  - hold: idx unchanged, but PITCH reloads from the table and NOTE_STB still pulses.
  - N_SLOTS=1: idx always 0 in every mode.
- MODE changes are sampled only at step events and take effect on that step.
  - Entering up-down keeps the current direction flag.
  - Entering up-down with idx at an endpoint uses the inward direction.
- GATE = (state==PLAY) && (PITCH != 0). It is combinational from registers, so no extra latency.
- Table writes:
  - A write lands at the clock edge and is visible on the next read.
  - A write to the playing slot does not change PITCH until the next step.
  - A write and a step event in the same cycle targeting the same slot: the step loads the OLD value; the new value is heard on the next visit.
- Arithmetic:
  - Tick counter width is ceil(log2(STEP_TICKS)).
  - No saturation is needed; the counter never exceeds STEP_TICKS-1.
  - Index arithmetic is modulo N_SLOTS, not modulo 2^IDX_W.

Test Plan (bench uses STEP_TICKS=4, N_SLOTS=4):
1. Reset check: hold RST_N=0 → PITCH=0, NOTE_STB=0, GATE=0, STEP_IDX=0. Write slots 0..3 = 191116, 340529, 286352, 227272; raise RUN in MODE 00 → STEP_IDX sequence 0,1,2,3,0, with NOTE_STB every 4 cycles and PITCH matching each slot.
2. Direction modes: MODE 01 from IDLE → sequence 3,2,1,0,3. MODE 10 → sequence 0,1,2,3,2,1,0,1. MODE 11 → STEP_IDX fixed while NOTE_STB still pulses every 4 cycles.
3. Rest slot: write slot 2 = 0, play up → GATE=0 only during step 2, NOTE_STB still pulses, PITCH=0.
4. Write collision: write slot 1 = 100 in the same cycle as the step event into slot 1 → PITCH=340529 for that step; 100 on the next visit to slot 1.
5. Stop priority: drop RUN on the step-event cycle → no NOTE_STB, GATE=0 next cycle, PITCH holds. Raise RUN again → restart at slot 0 with NOTE_STB.
6. Reset mid-play: assert RST_N low mid-step, asynchronously between clock edges → outputs clear immediately without a CLK edge, and table entries read 0 after release.
